sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter: NBITS, 8, frame length in bits (2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to capture one frame, sampled in IDLE or HOLD.
REQ-005 SHALL have port: abort  input  1  synchronous cancel of any frame in progress.
REQ-006 SHALL have port: s_in  input  1  serial data line.
REQ-007 SHALL have port: ready  input  1  consumer accepts the held frame.
REQ-008 SHALL have port: p_out  output  [0:NBITS-1]  parallel frame, driven directly from the shift register.
REQ-009 SHALL have port: valid  output  1  p_out holds a complete frame.
REQ-010 SHALL have port: busy  output  1  high in SHIFT.
REQ-011 SHALL have port: overrun  output  1  sticky lost-request flag.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-013 SHALL move IDLE->SHIFT on an edge with start=1, with no shift on that edge.
REQ-014 SHALL, in SHIFT, shift once per edge ({s_in, p_out[0:NBITS-2]}) via the active-low shift enable held low, for exactly NBITS edges counted 0..NBITS-1.
REQ-015 SHALL sample frame bit k on edge k+1 after the start edge, so that the first bit ends in p_out[NBITS-1] and the last bit ends in p_out[0].
REQ-016 SHALL move SHIFT->HOLD on the edge performing shift NBITS-1, with valid=1 from the following cycle (start-to-valid latency NBITS+1 cycles).
REQ-017 SHALL hold the shift enable high (no shift) in IDLE and HOLD, so that p_out stays stable while valid=1.
REQ-018 SHALL move HOLD->IDLE on an edge with ready=1 and start=0, with valid=0 from the next cycle.
REQ-019 SHALL move HOLD->SHIFT on an edge with ready=1 and start=1 (back-to-back frames, valid drops for a single cycle before the new frame).
REQ-020 SHALL set overrun on an edge with start=1 in SHIFT, or with start=1 and ready=0 in HOLD; that start SHALL be ignored.
REQ-021 SHALL keep overrun set until abort or reset clears it.
REQ-022 SHALL, on an edge with abort=1 in any state, go to IDLE with counter=0, valid=0, overrun=0, and p_out retained (not cleared).
REQ-023 SHALL give abort priority over start, ready and counter completion on the same edge.
REQ-024 SHALL ignore ready in IDLE and SHIFT.
REQ-025 SHALL size the counter as $clog2(NBITS) bits and SHALL NOT allow it to wrap past NBITS-1.

Reset
REQ-026 SHALL, while RST_n=0, force state=IDLE, counter=0, valid=0, busy=0, overrun=0 and p_out=all zeros, independent of clk.
REQ-027 SHALL drive the shift sub-module's active-high reset as the inversion of RST_n, with no other reset source.
REQ-028 SHALL, on reset mid-frame, discard the frame with no valid pulse, leaving the block in IDLE after release.
REQ-029 SHALL accept start on the first rising edge after RST_n deasserts.

Structure
REQ-030 SHALL place the state encoding (IDLE, SHIFT, HOLD) and the default NBITS in a shared package, sipo_pkg.
REQ-031 SHALL contain exactly one sub-module, sipo_shift (parameterised NBITS SIPO register, active-high async RST, active-low EN), instantiated once.
REQ-032 SHALL keep the FSM, counter and flags in sipo_frame_ctrl, with only registered outputs.

Verification
REQ-033 SHALL cover: reset then start, s_in=1,0,1,1,0,0,1,0 on shift edges 1..8, ready=1 -> valid high 9 cycles after start, p_out[0:7]=0100_1101, valid low one cycle after ready.
REQ-034 SHALL cover: frame completes, ready=0 for 5 cycles with s_in toggling -> p_out unchanged, valid held high.
REQ-035 SHALL cover: start during shift 3 -> overrun=1 and the frame still completes correctly; then abort -> overrun=0 and state IDLE.
REQ-036 SHALL cover: in HOLD, ready=1 and start=1 on the same edge -> valid low one cycle, a new 8-bit frame captured, second valid 9 cycles later.
REQ-037 SHALL cover: RST_n=0 asynchronously mid-SHIFT (between edges) -> p_out=0, busy=0, valid=0 immediately, and no valid after release.
REQ-038 SHALL cover: abort and start on the same edge in IDLE -> remains IDLE, busy stays 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared state encoding and default frame length for the SIPO frame controller.
package sipo_pkg;

    localparam int unsigned NBITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sipo_shift.sv
// NBITS-wide serial-in/parallel-out register: active-high async reset, active-low shift enable.
module sipo_shift #(
    parameter int unsigned NBITS = sipo_pkg::NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             en_n_i,
    input  logic             s_in_i,
    output logic [0:NBITS-1] p_o
);

    // New bit enters at index 0; the oldest bit drifts toward index NBITS-1.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            p_o <= '0;
        end else if (!en_n_i) begin
            p_o <= {s_in_i, p_o[0:NBITS-2]};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame capture controller: sequences one NBITS-bit serial frame into sipo_shift and holds it for a consumer.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int unsigned NBITS = sipo_pkg::NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             start,
    input  logic             abort,
    input  logic             s_in,
    input  logic             ready,
    output logic [0:NBITS-1] p_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(NBITS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             shift_en_n;

    sipo_shift #(.NBITS(NBITS)) u_shift (
        .clk    (clk),
        .rst_i  (~RST_n),
        .en_n_i (shift_en_n),
        .s_in_i (s_in),
        .p_o    (p_out)
    );

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Abort wins over everything and also suppresses the shift on its edge so p_out is retained.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        shift_en_n = 1'b1;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    shift_en_n = 1'b0;
                    if (start) begin
                        ovr_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(NBITS - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (ready) begin
                        state_d = start ? SHIFT : IDLE;
                        cnt_d   = '0;
                    end else if (start) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        valid_d = (state_d == HOLD);
        busy_d  = (state_d == SHIFT);
    end

    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed plus randomized checking of sipo_frame_ctrl against a frame-level reference model.
module tb_sipo_frame_ctrl;

    localparam int unsigned N = 8;

    logic         clk   = 1'b0;
    logic         RST_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         s_in  = 1'b0;
    logic         ready = 1'b0;
    logic [0:N-1] p_out;
    logic         valid;
    logic         busy;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 = waiting, 1 = collecting bits, 2 = frame held.
    int           m_phase = 0;
    int           m_got   = 0;
    logic [0:N-1] m_p     = '0;
    logic         m_ovr   = 1'b0;

    logic [0:N-1] frame_bits;
    logic [0:N-1] exp_frame;

    sipo_frame_ctrl #(.NBITS(N)) dut (
        .clk     (clk),
        .RST_n   (RST_n),
        .start   (start),
        .abort   (abort),
        .s_in    (s_in),
        .ready   (ready),
        .p_out   (p_out),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk_vec({tag, ".p_out"}, p_out, m_p);
        chk_bit({tag, ".valid"}, valid, logic'(m_phase == 2));
        chk_bit({tag, ".busy"}, busy, logic'(m_phase == 1));
        chk_bit({tag, ".overrun"}, overrun, m_ovr);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_got   = 0;
        m_p     = '0;
        m_ovr   = 1'b0;
    endtask

    // One rising edge of the specified behaviour, using the inputs that were present at the edge.
    task automatic model_edge();
        if (abort) begin
            m_phase = 0;
            m_got   = 0;
            m_ovr   = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_got   = 0;
            end
        end else if (m_phase == 1) begin
            for (int j = N - 1; j > 0; j--) m_p[j] = m_p[j-1];
            m_p[0] = s_in;
            m_got++;
            if (start) m_ovr = 1'b1;
            if (m_got == N) m_phase = 2;
        end else begin
            if (ready) begin
                m_phase = start ? 1 : 0;
                m_got   = 0;
            end else if (start) begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic ab, input logic si, input logic rd, input string tag);
        start = st;
        abort = ab;
        s_in  = si;
        ready = rd;
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    // Expected parallel word for a frame sent bit 0 first: first bit lands at the far end.
    task automatic frame_to_pout(input logic [0:N-1] bits, output logic [0:N-1] pw);
        for (int j = 0; j < N; j++) pw[j] = bits[N-1-j];
    endtask

    initial begin
        logic [0:N-1] want33;
        logic [0:N-1] held;

        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        RST_n = 1'b1;

        // Basic frame 1,0,1,1,0,0,1,0 then ready.
        frame_bits = 8'b1011_0010;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f1.start");
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, frame_bits[k], 1'b0, "f1.shift");
        want33 = 8'b0100_1101;
        chk_vec("f1.pout_literal", p_out, want33);
        chk_bit("f1.valid_at_latency", valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "f1.ready");
        chk_bit("f1.valid_dropped", valid, 1'b0);

        // Held frame stays put while ready is low and s_in toggles.
        frame_bits = 8'b1100_0101;
        frame_to_pout(frame_bits, exp_frame);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f2.start");
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, frame_bits[k], 1'b0, "f2.shift");
        held = p_out;
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, logic'(k % 2), 1'b0, "f2.hold");
        chk_vec("f2.pout_stable", p_out, exp_frame);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "f2.ready");
        chk_vec("f2.pout_after_ready", p_out, held);

        // Start during the third shift raises overrun; frame is unaffected; abort clears it.
        frame_bits = 8'b0110_1001;
        frame_to_pout(frame_bits, exp_frame);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f3.start");
        for (int k = 0; k < N; k++) cyc(logic'(k == 2), 1'b0, frame_bits[k], 1'b0, "f3.shift");
        chk_vec("f3.pout_frame", p_out, exp_frame);
        chk_bit("f3.overrun_set", overrun, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "f3.abort");
        chk_bit("f3.overrun_cleared", overrun, 1'b0);
        chk_vec("f3.pout_retained", p_out, exp_frame);

        // Back-to-back: ready and start together in HOLD.
        frame_bits = 8'b1110_0001;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f4.start");
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, frame_bits[k], 1'b0, "f4.shift");
        frame_bits = 8'b0001_1110;
        frame_to_pout(frame_bits, exp_frame);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "f5.ready_start");
        chk_bit("f5.valid_low", valid, 1'b0);
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, frame_bits[k], 1'b0, "f5.shift");
        chk_vec("f5.pout_frame", p_out, exp_frame);
        chk_bit("f5.overrun_clear", overrun, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "f5.ready");

        // Asynchronous reset between edges in the middle of a frame.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f6.start");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "f6.shift");
        #2;
        RST_n = 1'b0;
        #1;
        model_reset();
        check_all("f6.async_reset");
        @(posedge clk);
        @(negedge clk);
        RST_n = 1'b1;
        for (int k = 0; k < N + 2; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "f6.after_release");

        // Abort and start together in IDLE.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "f7.abort_start");
        chk_bit("f7.busy_low", busy, 1'b0);

        // Start accepted on the first edge after reset release.
        #2;
        RST_n = 1'b0;
        #1;
        model_reset();
        check_all("f8.reset");
        @(negedge clk);
        RST_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "f8.first_edge_start");
        chk_bit("f8.busy_high", busy, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(logic'($urandom_range(0, 5) == 0),
                logic'($urandom_range(0, 39) == 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 2) == 0),
                "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
